// File: rtl/perceptron_predictor_param_if.sv
// Decode/execute-side port bundle for the parametrised perceptron branch predictor.
// The predictor connects through the slave modport; the fetch/decode/execute side uses master.
interface perceptron_predictor_param_if #(
   parameter int PC_WIDTH = 32
);
   logic                dec_valid;
   logic [PC_WIDTH-1:0] dec_pc;
   logic                pred_valid;
   logic                prediction;
   logic                ready;
   logic                ex_valid;
   logic [PC_WIDTH-1:0] ex_pc;
   logic                ex_taken;
   logic [31:0]         stat_branches;
   logic [31:0]         stat_trains;

   modport master (
      output dec_valid, dec_pc, ex_valid, ex_pc, ex_taken,
      input  pred_valid, prediction, ready, stat_branches, stat_trains
   );

   modport slave (
      input  dec_valid, dec_pc, ex_valid, ex_pc, ex_taken,
      output pred_valid, prediction, ready, stat_branches, stat_trains
   );
endinterface

// File: rtl/perceptron_predictor_param.sv
// Self-initialising global-history perceptron branch predictor with parametrised table geometry.
// Define PRED_STATS_EN to build the resolved-branch and training-update counters.
module perceptron_predictor_param #(
   parameter int PC_WIDTH     = 32,
   parameter int TABLE_DEPTH  = 64,
   parameter int HIST_LEN     = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int THETA        = 44
) (
   input  logic                        clk,
   input  logic                        rst_n,
   perceptron_predictor_param_if.slave bp
);

   localparam int IDX   = $clog2(TABLE_DEPTH);
   localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_WIDTH;
   localparam int ACC_W = WEIGHT_WIDTH + $clog2(HIST_LEN + 1) + 1;

   localparam logic signed [WEIGHT_WIDTH-1:0] W_MAX = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
   localparam logic signed [WEIGHT_WIDTH-1:0] W_MIN = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
   localparam logic signed [WEIGHT_WIDTH-1:0] W_ONE = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic signed [31:0]             THETA_S = THETA;
   localparam logic [IDX-1:0]                 LAST_ROW = IDX'(TABLE_DEPTH - 1);

   typedef enum logic {INIT, RUN} state_t;

   function automatic logic signed [WEIGHT_WIDTH-1:0] sat_step(
      input logic signed [WEIGHT_WIDTH-1:0] w,
      input logic                           up
   );
      if (up) return (w == W_MAX) ? w : w + W_ONE;
      else    return (w == W_MIN) ? w : w - W_ONE;
   endfunction

   function automatic logic signed [ACC_W-1:0] sext(input logic [WEIGHT_WIDTH-1:0] w);
      return {{(ACC_W-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w};
   endfunction

   // Bias plus +/-w_i per history bit; ACC_W leaves headroom so the sum never overflows.
   function automatic logic signed [ACC_W-1:0] dot(
      input logic [ROW_W-1:0]    row,
      input logic [HIST_LEN-1:0] h
   );
      logic signed [ACC_W-1:0] acc;
      acc = sext(row[WEIGHT_WIDTH-1:0]);
      for (int i = 1; i <= HIST_LEN; i++) begin
         if (h[i-1]) acc = acc + sext(row[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
         else        acc = acc - sext(row[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]);
      end
      return acc;
   endfunction

   // A weight moves up exactly when t*x_i = +1, i.e. outcome agrees with that history bit.
   function automatic logic [ROW_W-1:0] train_row(
      input logic [ROW_W-1:0]    row,
      input logic [HIST_LEN-1:0] h,
      input logic                taken
   );
      logic [ROW_W-1:0] nr;
      nr = row;
      nr[WEIGHT_WIDTH-1:0] = sat_step(row[WEIGHT_WIDTH-1:0], taken);
      for (int i = 1; i <= HIST_LEN; i++)
         nr[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] =
            sat_step(row[i*WEIGHT_WIDTH +: WEIGHT_WIDTH], taken == h[i-1]);
      return nr;
   endfunction

   state_t               state;
   logic [IDX-1:0]       init_cnt;
   logic                 ready_q;
   logic                 vld_p1;
   logic                 pred_p1;
   logic [HIST_LEN-1:0]  history;
   logic [ROW_W-1:0]     table_mem [TABLE_DEPTH];

   logic [IDX-1:0]          dec_idx;
   logic [IDX-1:0]          ex_idx;
   logic [ROW_W-1:0]        row_dec;
   logic [ROW_W-1:0]        row_ex;
   logic [ROW_W-1:0]        row_new;
   logic signed [ACC_W-1:0] y_dec;
   logic signed [ACC_W-1:0] y_ex;
   logic signed [31:0]      y_ex_w;
   logic                    run;
   logic                    mispredict;
   logic                    low_conf;
   logic                    train_we;
   logic                    unused_pc;

   assign run       = (state == RUN);
   assign dec_idx   = bp.dec_pc[IDX+1:2];
   assign ex_idx    = bp.ex_pc[IDX+1:2];
   assign unused_pc = ^{bp.dec_pc, bp.ex_pc};

   // Stage p0: both lookups read the committed table and history, no write bypass.
   assign row_dec    = table_mem[dec_idx];
   assign row_ex     = table_mem[ex_idx];
   assign y_dec      = dot(row_dec, history);
   assign y_ex       = dot(row_ex, history);
   assign y_ex_w     = {{(32-ACC_W){y_ex[ACC_W-1]}}, y_ex};
   assign mispredict = (~y_ex[ACC_W-1]) != bp.ex_taken;
   assign low_conf   = (y_ex_w <= THETA_S) && (y_ex_w >= -THETA_S);
   assign train_we   = run && bp.ex_valid && (mispredict || low_conf);
   assign row_new    = train_row(row_ex, history, bp.ex_taken);

   always_ff @(posedge clk) begin
      if (state == INIT) table_mem[init_cnt] <= '0;
      else if (train_we) table_mem[ex_idx]   <= row_new;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= INIT;
         init_cnt <= '0;
         ready_q  <= 1'b0;
         vld_p1   <= 1'b0;
         pred_p1  <= 1'b0;
         history  <= '0;
      end else begin
         case (state)
            INIT: begin
               vld_p1   <= 1'b0;
               init_cnt <= init_cnt + IDX'(1);
               if (init_cnt == LAST_ROW) begin
                  state   <= RUN;
                  ready_q <= 1'b1;
               end
            end
            RUN: begin
               // Stage p1: registered prediction; history follows resolved outcomes only.
               vld_p1 <= bp.dec_valid;
               if (bp.dec_valid) pred_p1 <= ~y_dec[ACC_W-1];
               if (bp.ex_valid)  history <= HIST_LEN'({history, bp.ex_taken});
            end
            default: state <= INIT;
         endcase
      end
   end

   assign bp.pred_valid = vld_p1;
   assign bp.prediction = pred_p1;
   assign bp.ready      = ready_q;

`ifdef PRED_STATS_EN
   logic [31:0] branch_cnt;
   logic [31:0] train_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt <= '0;
         train_cnt  <= '0;
      end else begin
         if (run && bp.ex_valid && (branch_cnt != '1)) branch_cnt <= branch_cnt + 32'd1;
         if (train_we && (train_cnt != '1))            train_cnt  <= train_cnt + 32'd1;
      end
   end

   assign bp.stat_branches = branch_cnt;
   assign bp.stat_trains   = train_cnt;
`else
   assign bp.stat_branches = '0;
   assign bp.stat_trains   = '0;
`endif

endmodule

// File: tb/tb_perceptron_predictor_param.sv
// Directed bench for perceptron_predictor_param: init timing, prediction, training,
// saturation, simultaneous decode/execute and asynchronous reset.
module tb_perceptron_predictor_param;
   localparam int PCW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_b;
   logic [31:0] exp_t;

   always #5 clk = ~clk;

   perceptron_predictor_param_if #(.PC_WIDTH(PCW)) bp();
   perceptron_predictor_param_if #(.PC_WIDTH(PCW)) bp_sat();

   perceptron_predictor_param #(
      .PC_WIDTH(PCW), .TABLE_DEPTH(64), .HIST_LEN(4), .WEIGHT_WIDTH(4), .THETA(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bp(bp)
   );

   perceptron_predictor_param #(
      .PC_WIDTH(PCW), .TABLE_DEPTH(64), .HIST_LEN(4), .WEIGHT_WIDTH(4), .THETA(1000)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n), .bp(bp_sat)
   );

   task automatic step(input logic dv, input logic [31:0] dpc,
                       input logic ev, input logic [31:0] epc, input logic tk);
      @(negedge clk);
      bp.dec_valid = dv; bp.dec_pc = dpc;
      bp.ex_valid = ev; bp.ex_pc = epc; bp.ex_taken = tk;
      @(posedge clk); #1;
      bp.dec_valid = 1'b0; bp.ex_valid = 1'b0;
   endtask

   task automatic step_sat(input logic dv, input logic ev, input logic tk);
      @(negedge clk);
      bp_sat.dec_valid = dv; bp_sat.dec_pc = 32'h100;
      bp_sat.ex_valid = ev; bp_sat.ex_pc = 32'h100; bp_sat.ex_taken = tk;
      @(posedge clk); #1;
      bp_sat.dec_valid = 1'b0; bp_sat.ex_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      for (int i = 0; i < 100 && bp.ready !== 1'b1; i++) begin
         @(posedge clk); #1;
      end
      checks++;
      if (bp.ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_ready_timeout got=%b exp=1", bp.ready);
      end
   endtask

   task automatic test_reset();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (bp.ready !== 1'b0) begin
         failures++; $display("FAIL reset_ready got=%b exp=0", bp.ready);
      end
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b00) begin
         failures++; $display("FAIL reset_pred got=%b exp=00", {bp.pred_valid, bp.prediction});
      end
      checks++;
      if ({bp.stat_branches, bp.stat_trains} !== 64'd0) begin
         failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", bp.stat_branches, bp.stat_trains);
      end
      bp.dec_valid = 1'b1; bp.dec_pc = 32'h100;
      bp.ex_valid = 1'b1; bp.ex_pc = 32'h100; bp.ex_taken = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bp.ready !== (i == 63)) begin
            failures++; $display("FAIL init_ready cycle=%0d got=%b exp=%b", i + 1, bp.ready, (i == 63));
         end
         checks++;
         if (bp.pred_valid !== 1'b0) begin
            failures++; $display("FAIL init_dec_ignored cycle=%0d got=%b exp=0", i + 1, bp.pred_valid);
         end
      end
      bp.dec_valid = 1'b0; bp.ex_valid = 1'b0;
      checks++;
      if ({bp.stat_branches, bp.stat_trains} !== 64'd0) begin
         failures++; $display("FAIL init_ex_ignored_stats got=%0d/%0d exp=0/0", bp.stat_branches, bp.stat_trains);
      end
   endtask

   task automatic test_cold_prediction();
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL cold_pred got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
      step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b01) begin
         failures++; $display("FAIL idle_hold got=%b exp=01", {bp.pred_valid, bp.prediction});
      end
   endtask

   task automatic test_single_training();
      // row0 -> w0=-1, w1..4=+1; y=-5 at zero history
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b10) begin
         failures++; $display("FAIL train_nt_pred got=%b exp=10", {bp.pred_valid, bp.prediction});
      end
      step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL other_row_untouched got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
      // |y|=5 > THETA and correct: no update; then a taken update brings row0 back to zero
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL theta_skip got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
`ifdef PRED_STATS_EN
      exp_b = 32'd3; exp_t = 32'd2;
`else
      exp_b = 32'd0; exp_t = 32'd0;
`endif
      checks++;
      if (bp.stat_branches !== exp_b) begin
         failures++; $display("FAIL stat_branches got=%0d exp=%0d", bp.stat_branches, exp_b);
      end
      checks++;
      if (bp.stat_trains !== exp_t) begin
         failures++; $display("FAIL stat_trains got=%0d exp=%0d", bp.stat_trains, exp_t);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL simul_nt_pre got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b10) begin
         failures++; $display("FAIL simul_nt_post got=%b exp=10", {bp.pred_valid, bp.prediction});
      end
      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b10) begin
         failures++; $display("FAIL simul_tk_pre got=%b exp=10", {bp.pred_valid, bp.prediction});
      end
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL simul_tk_post got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
      step(1'b1, 32'h104, 1'b1, 32'h104, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL simul_row1_pre got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
      step(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL b2b_committed got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
   endtask

   task automatic test_history();
      do_reset();
      // row1 -> w0=-1, w1..4=+1, so y = -1 + sum(x_i)
      step(1'b0, 32'h0, 1'b1, 32'h104, 1'b0);
      step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b10) begin
         failures++; $display("FAIL hist_zero got=%b exp=10", {bp.pred_valid, bp.prediction});
      end
      for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 32'h108, 1'b1);
      step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL hist_ones got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
      step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL hist_dec_no_shift got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
      step(1'b0, 32'h0, 1'b1, 32'h108, 1'b0);
      step(1'b0, 32'h0, 1'b1, 32'h108, 1'b0);
      step(1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b10) begin
         failures++; $display("FAIL hist_1100 got=%b exp=10", {bp.pred_valid, bp.prediction});
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1'b0, 32'h0, 1'b1, 32'hA0, 1'b0);
      step(1'b1, 32'hA0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b10) begin
         failures++; $display("FAIL row40_trained got=%b exp=10", {bp.pred_valid, bp.prediction});
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bp.ready, bp.pred_valid} !== 2'b00) begin
         failures++; $display("FAIL async_run got=%b exp=00", {bp.ready, bp.pred_valid});
      end
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++;
      if (bp.ready !== 1'b0) begin
         failures++; $display("FAIL init10_ready got=%b exp=0", bp.ready);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bp.ready, bp.pred_valid} !== 2'b00) begin
         failures++; $display("FAIL async_init got=%b exp=00", {bp.ready, bp.pred_valid});
      end
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bp.ready !== (i == 63)) begin
            failures++; $display("FAIL reinit_ready cycle=%0d got=%b exp=%b", i + 1, bp.ready, (i == 63));
         end
      end
      step(1'b1, 32'hA0, 1'b0, 32'h0, 1'b0);
      checks++;
      if ({bp.pred_valid, bp.prediction} !== 2'b11) begin
         failures++; $display("FAIL reinit_row40_zero got=%b exp=11", {bp.pred_valid, bp.prediction});
      end
   endtask

   task automatic test_saturation();
      do_reset();
      // w0 -> -min(k,8), w_i -> min(k,7): y stays negative unless a weight wraps
      for (int k = 0; k < 20; k++) begin
         step_sat(1'b0, 1'b1, 1'b0);
         step_sat(1'b1, 1'b0, 1'b0);
         checks++;
         if ({bp_sat.pred_valid, bp_sat.prediction} !== 2'b10) begin
            failures++;
            $display("FAIL sat_pred update=%0d got=%b exp=10", k + 1, {bp_sat.pred_valid, bp_sat.prediction});
         end
      end
`ifdef PRED_STATS_EN
      exp_b = 32'd20; exp_t = 32'd20;
`else
      exp_b = 32'd0; exp_t = 32'd0;
`endif
      checks++;
      if (bp_sat.stat_trains !== exp_t) begin
         failures++; $display("FAIL sat_stat_trains got=%0d exp=%0d", bp_sat.stat_trains, exp_t);
      end
      checks++;
      if (bp_sat.stat_branches !== exp_b) begin
         failures++; $display("FAIL sat_stat_branches got=%0d exp=%0d", bp_sat.stat_branches, exp_b);
      end
   endtask

   initial begin
      bp.dec_valid = 1'b0; bp.dec_pc = '0; bp.ex_valid = 1'b0; bp.ex_pc = '0; bp.ex_taken = 1'b0;
      bp_sat.dec_valid = 1'b0; bp_sat.dec_pc = '0; bp_sat.ex_valid = 1'b0;
      bp_sat.ex_pc = '0; bp_sat.ex_taken = 1'b0;
      test_reset();
      test_cold_prediction();
      test_single_training();
      test_simultaneous();
      test_back_to_back();
      test_history();
      test_async_reset();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
